// File: rtl/pulse_meter.sv
// Per-pulse width/gap meter on an asynchronous trigger line, with a valid/ack
// result handshake and sticky overflow/overrun flags.
module pulse_meter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sgn,
  input  logic             ack,
  output logic [WIDTH-1:0] width,
  output logic [WIDTH-1:0] gap,
  output logic [4:0]       count,
  output logic             valid,
  output logic             ovf,
  output logic             lost,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] s;
  logic                   s_d;
  logic                   s_last;
  logic [SYNC_STAGES:0]   prime;
  logic                   ready;
  logic                   rise;
  logic                   fall;
  logic [1:0]             state;
  logic [WIDTH-1:0]       hcnt;
  logic [WIDTH-1:0]       lcnt;
  logic [WIDTH-1:0]       gap_l;
  logic                   publish;
  logic                   ovf_set;
  logic                   lost_set;

  assign s_last = s[SYNC_STAGES-1];

  // Edges are only trusted once the synchronizer and s_d hold real samples,
  // so a line already high at reset release never looks like a rise.
  assign ready = prime[SYNC_STAGES];
  assign rise  = ready & s_last & ~s_d;
  assign fall  = ready & ~s_last & s_d;

  assign publish  = (state == HIGH) & fall;
  assign ovf_set  = publish & ((hcnt == MAX) | (gap_l == MAX));
  assign lost_set = publish & valid & ~ack;
  assign busy     = (state == HIGH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s     <= '0;
      s_d   <= 1'b0;
      prime <= '0;
    end else begin
      s     <= {s[SYNC_STAGES-2:0], sgn};
      s_d   <= s_last;
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
      lcnt  <= '0;
      gap_l <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state <= HIGH;
          hcnt  <= ONE;
          gap_l <= '0;
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            lcnt  <= ONE;
          end else if (s_last && hcnt != MAX) begin
            hcnt <= hcnt + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            gap_l <= lcnt;
            hcnt  <= ONE;
          end else if (!s_last && lcnt != MAX) begin
            lcnt <= lcnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      width <= '0;
      gap   <= '0;
      count <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      lost  <= 1'b0;
    end else begin
      if (publish) begin
        width <= hcnt;
        gap   <= gap_l;
        count <= count + 5'd1;
      end
      valid <= publish | (valid & ~ack);
      ovf   <= ovf_set | (ovf & ~ack);
      lost  <= lost_set | (lost & ~ack);
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: results queued as pulses are driven,
// popped and compared whenever the meter publishes.
module tb_pulse_meter;

  logic       clock = 1'b0;
  logic       reset;
  logic       sgn;
  logic       ack;
  logic [7:0] width;
  logic [7:0] gap;
  logic [4:0] count;
  logic       valid;
  logic       ovf;
  logic       lost;
  logic       busy;

  pulse_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sgn(sgn), .ack(ack),
    .width(width), .gap(gap), .count(count),
    .valid(valid), .ovf(ovf), .lost(lost), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] w;
    logic [7:0] g;
    logic [4:0] c;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   low_run = 0;
  int   cnt = 0;
  bit   first = 1'b1;

  logic       seen_valid = 1'b0;
  logic [4:0] seen_count = '0;

  // A result is new when valid rises or the count moves while valid is held
  always @(negedge clock) begin
    res_t e;
    if (reset) begin
      seen_valid = 1'b0;
      seen_count = '0;
    end else begin
      if (valid && (!seen_valid || count != seen_count)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got width=%0d gap=%0d count=%0d, required no result",
                   width, gap, count);
        end else begin
          e = q.pop_front();
          if ({width, gap, count} !== {e.w, e.g, e.c}) begin
            errors++;
            $display("FAIL result: got width=%0d gap=%0d count=%0d, required width=%0d gap=%0d count=%0d",
                     width, gap, count, e.w, e.g, e.c);
          end
        end
      end
      seen_valid = valid;
      seen_count = count;
    end
  end

  task automatic model_reset();
    q.delete();
    cnt     = 0;
    first   = 1'b1;
    low_run = 0;
  endtask

  task automatic expect_pulse(input int p);
    res_t e;
    e.w = (p > 255) ? 8'd255 : 8'(p);
    e.g = first ? 8'd0 : ((low_run > 255) ? 8'd255 : 8'(low_run));
    cnt = (cnt + 1) % 32;
    e.c = 5'(cnt);
    q.push_back(e);
    first   = 1'b0;
    low_run = 0;
  endtask

  task automatic drive_high(input int p);
    expect_pulse(p);
    sgn = 1'b1;
    repeat (p) begin
      @(posedge clock);
      #1;
    end
  endtask

  // ack is held for the ack_at-th low posedge only (0 = never)
  task automatic drive_low(input int l, input int ack_at);
    sgn = 1'b0;
    for (int i = 1; i <= l; i++) begin
      ack = (i == ack_at);
      @(posedge clock);
      #1;
      low_run++;
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sgn   = 1'b0;
    ack   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({valid, ovf, lost, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b ovf=%b lost=%b busy=%b, required all 0", valid, ovf, lost, busy);
    end
    checks++;
    if ({width, gap, count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_data: got width=%0d gap=%0d count=%0d, required 0", width, gap, count);
    end
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    expect_pulse(6);
    sgn = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_early: got %b, required 0", busy);
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b, required 1", busy);
    end
    repeat (3) begin
      @(posedge clock); #1;
    end
    drive_low(2, 0);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_early: got %b, required 0", valid);
    end
    drive_low(1, 0);
    checks++;
    if ({valid, ovf, lost, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_flags: got valid=%b ovf=%b lost=%b busy=%b, required 1 0 0 0", valid, ovf, lost, busy);
    end
    drive_low(1, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got valid=%b, required 0", valid);
    end
    drive_low(2, 0);
  endtask

  task automatic test_sequence();
    drive_high(4);
    drive_low(9, 4);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_ack1: got valid=%b, required 0", valid);
    end
    drive_high(3);
    drive_low(4, 4);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_ack2: got valid=%b, required 0", valid);
    end
  endtask

  task automatic test_saturate();
    drive_high(300);
    drive_low(4, 0);
    checks++;
    if ({valid, ovf} !== 2'b11) begin
      errors++;
      $display("FAIL sat_ovf: got valid=%b ovf=%b, required 1 1", valid, ovf);
    end
    drive_low(1, 1);
    checks++;
    if ({valid, ovf} !== 2'b00) begin
      errors++;
      $display("FAIL sat_clear: got valid=%b ovf=%b, required 0 0", valid, ovf);
    end
  endtask

  task automatic test_back_to_back();
    drive_high(3);
    drive_low(4, 0);
    checks++;
    if ({valid, lost} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b lost=%b, required 1 0", valid, lost);
    end
    drive_high(3);
    drive_low(4, 0);
    checks++;
    if ({valid, lost} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_lost: got valid=%b lost=%b, required 1 1", valid, lost);
    end
    drive_low(1, 1);
    checks++;
    if ({valid, lost} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_clear: got valid=%b lost=%b, required 0 0", valid, lost);
    end
    drive_high(3);
    drive_low(4, 0);
    drive_high(3);
    drive_low(3, 3);
    checks++;
    if ({valid, lost} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_ack_publish: got valid=%b lost=%b, required 1 0", valid, lost);
    end
    drive_low(1, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_ack: got valid=%b, required 0", valid);
    end
  endtask

  task automatic test_reset_mid_pulse();
    sgn = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({valid, busy, count} !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got valid=%b busy=%b count=%0d, required 0 0 0", valid, busy, count);
    end
    model_reset();
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy: got %b, required 0", busy);
    end
    drive_low(4, 0);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_partial: got valid=%b, required 0", valid);
    end
    drive_high(5);
    drive_low(4, 0);
    checks++;
    if ({valid, count} !== {1'b1, 5'd1}) begin
      errors++;
      $display("FAIL mid_reset_result: got valid=%b count=%0d, required 1 1", valid, count);
    end
    drive_low(1, 1);
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    drive_low(3, 0);
    for (int i = 0; i < 33; i++) begin
      drive_high(2);
      drive_low(4, 4);
    end
    checks++;
    if ({valid, count} !== {1'b0, 5'd1}) begin
      errors++;
      $display("FAIL wrap_count: got valid=%b count=%0d, required 0 1", valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_saturate();
    test_back_to_back();
    test_reset_mid_pulse();
    test_wrap();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL results_pending: got %0d unpublished results, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
